// File: rtl/keycode_pkg.sv
// Package: keycode_pkg
// Shared keycode constants, the fire FSM state type and the motion direction
// encoding used by keycode_cmd_decoder.
package keycode_pkg;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2,
    WAIT_REL = 2'd3
  } fire_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

endpackage

// File: rtl/frame_edge_sync.sv
// Module: frame_edge_sync
// Brings the asynchronous frame clock into the clk domain through a two-flop
// synchroniser, detects its rising edge and registers the result, so
// frame_tick is a one-cycle pulse three clk edges after frame_clk rises.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous, active-high reset
//   frame_clk  in  asynchronous frame clock
//   frame_tick out one-cycle pulse per frame_clk rising edge
module frame_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic tick_q,  tick_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/keycode_cmd_decoder.sv
// Module: keycode_cmd_decoder
// Decodes the keycode word into frame-synchronous cannon commands: a signed
// X step (with acceleration after a continuous hold) and a one-cycle fire
// request gated by shot_active and a frame-counted cooldown.
// Configuration macro: AUTOFIRE_EN -- when defined, COOLDOWN returns to IDLE
// so a held fire key refires; otherwise the key must be released first.
// Ports:
//   Clk             in  system clock
//   Reset           in  synchronous, active-high reset
//   frame_clk       in  asynchronous frame clock
//   keycode[7:0]    in  current keycode, 8'h00 = no key
//   shot_active     in  a missile is in flight; blocks firing
//   frame_tick      out one-Clk pulse per frame
//   cannon_x_motion out [9:0] two's-complement X step, held between ticks
//   fire_pulse      out one-Clk shot request
//   fire_state      out [1:0] fire FSM state (debug)
module keycode_cmd_decoder
  import keycode_pkg::*;
#(
  parameter logic [7:0] KEY_LEFT        = KC_LEFT,
  parameter logic [7:0] KEY_RIGHT       = KC_RIGHT,
  parameter logic [7:0] KEY_FIRE        = KC_SPACE,
  parameter int         STEP_SLOW       = 1,
  parameter int         STEP_FAST       = 2,
  parameter int         ACCEL_FRAMES    = 8,
  parameter int         COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       shot_active,
  output logic       frame_tick,
  output logic [9:0] cannon_x_motion,
  output logic       fire_pulse,
  output logic [1:0] fire_state
);

  localparam logic [7:0] ACCEL_W = 8'(ACCEL_FRAMES);
  localparam logic [7:0] CD_W    = 8'(COOLDOWN_FRAMES);
  localparam logic [9:0] SLOW_W  = 10'(STEP_SLOW);
  localparam logic [9:0] FAST_W  = 10'(STEP_FAST);

  logic [7:0]  kc_q,     kc_d;
  dir_t        dir_q,    dir_d;
  logic [7:0]  hold_q,   hold_d;
  logic [9:0]  motion_q, motion_d;
  fire_state_t state_q,  state_d;
  logic [7:0]  cd_q,     cd_d;

  dir_t       dir_cur;
  logic [9:0] step;
  logic       fire_pulse_c;

  frame_edge_sync u_sync (
    .clk        (Clk),
    .rst        (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Motion: direction and hold count advance only on frame_tick. The step is
  // chosen from the updated hold count, so a reversal or fresh press
  // produces the slow step on that same tick.
  always_comb begin
    kc_d     = keycode;
    dir_d    = dir_q;
    hold_d   = hold_q;
    motion_d = motion_q;
    step     = SLOW_W;
    dir_cur  = DIR_NONE;
    if (kc_q == KEY_RIGHT || kc_q == KC_D) begin
      dir_cur = DIR_RIGHT;
    end else if (kc_q == KEY_LEFT || kc_q == KC_A) begin
      dir_cur = DIR_LEFT;
    end
    if (frame_tick) begin
      if (dir_cur == DIR_NONE || dir_cur != dir_q) begin
        hold_d = 8'd0;
      end else if (hold_q < ACCEL_W) begin
        hold_d = hold_q + 8'd1;
      end
      dir_d = dir_cur;
      step  = (hold_d >= ACCEL_W) ? FAST_W : SLOW_W;
      case (dir_cur)
        DIR_RIGHT: motion_d = step;
        DIR_LEFT:  motion_d = 10'd0 - step;
        default:   motion_d = 10'd0;
      endcase
    end
  end

  // Fire FSM. The cooldown exit test runs every Clk (not only on ticks) so a
  // zero cooldown leaves COOLDOWN on the first Clk after FIRE.
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    fire_pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && kc_q == KEY_FIRE && !shot_active) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        fire_pulse_c = 1'b1;
        cd_d         = CD_W;
        state_d      = COOLDOWN;
      end
      COOLDOWN: begin
        if (cd_q == 8'd0) begin
`ifdef AUTOFIRE_EN
          state_d = IDLE;
`else
          state_d = WAIT_REL;
`endif
        end else if (frame_tick) begin
          cd_d = cd_q - 8'd1;
        end
      end
      WAIT_REL: begin
        if (frame_tick && kc_q != KEY_FIRE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q     <= KC_NONE;
      dir_q    <= DIR_NONE;
      hold_q   <= 8'd0;
      motion_q <= 10'd0;
      state_q  <= IDLE;
      cd_q     <= 8'd0;
    end else begin
      kc_q     <= kc_d;
      dir_q    <= dir_d;
      hold_q   <= hold_d;
      motion_q <= motion_d;
      state_q  <= state_d;
      cd_q     <= cd_d;
    end
  end

  assign cannon_x_motion = motion_q;
  assign fire_pulse      = fire_pulse_c;
  assign fire_state      = state_q;

endmodule

// File: tb/tb_keycode_cmd_decoder.sv
module tb_keycode_cmd_decoder;

`ifdef AUTOFIRE_EN
  localparam int CD = 3;
`else
  localparam int CD = 15;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       shot_active = 1'b0;
  logic       frame_tick;
  logic [9:0] cannon_x_motion;
  logic       fire_pulse;
  logic [1:0] fire_state;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  int pulse_cycles = 0;
  logic prev_pulse = 1'b0;

  keycode_cmd_decoder #(.COOLDOWN_FRAMES(CD)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .keycode         (keycode),
    .shot_active     (shot_active),
    .frame_tick      (frame_tick),
    .cannon_x_motion (cannon_x_motion),
    .fire_pulse      (fire_pulse),
    .fire_state      (fire_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // pulse monitor, sampled on the falling edge
  always @(negedge Clk) begin
    if (fire_pulse === 1'b1) begin
      pulse_cycles = pulse_cycles + 1;
      if (prev_pulse !== 1'b1) pulse_count = pulse_count + 1;
    end
    prev_pulse = fire_pulse;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // one frame: 6 Clk high, 6 Clk low; tick lands 3 Clk after the rise
  task automatic run_frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) run_frame();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    checks++; if (cannon_x_motion !== 10'd0) begin errors++; $display("FAIL reset_motion: got %h expected 000", cannon_x_motion); end
    checks++; if (fire_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", fire_pulse); end
    checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fire_state); end
  endtask

  task automatic test_frame_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      checks++;
      if (frame_tick !== (k == 3)) begin
        errors++; $display("FAIL tick_latency clk %0d: got %b expected %b", k, frame_tick, (k == 3));
      end
    end
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    checks++; if (cannon_x_motion !== 10'd0) begin errors++; $display("FAIL tick_nokey_motion: got %h expected 000", cannon_x_motion); end
  endtask

  task automatic test_motion();
    logic [9:0] exp;
    keycode = 8'h4F;
    for (int i = 0; i < 10; i++) begin
      run_frame();
      exp = (i < 8) ? 10'd1 : 10'd2;
      checks++;
      if (cannon_x_motion !== exp) begin
        errors++; $display("FAIL motion_right tick %0d: got %h expected %h", i + 1, cannon_x_motion, exp);
      end
    end
    keycode = 8'h50; run_frame();
    checks++; if (cannon_x_motion !== 10'h3FF) begin errors++; $display("FAIL motion_reverse_left: got %h expected 3ff", cannon_x_motion); end
    keycode = 8'h07; run_frame();
    checks++; if (cannon_x_motion !== 10'h001) begin errors++; $display("FAIL motion_alias_d: got %h expected 001", cannon_x_motion); end
    keycode = 8'h00; run_frame();
    checks++; if (cannon_x_motion !== 10'h000) begin errors++; $display("FAIL motion_release: got %h expected 000", cannon_x_motion); end
    keycode = 8'h04;
    for (int i = 0; i < 9; i++) begin
      run_frame();
      exp = (i < 8) ? 10'h3FF : 10'h3FE;
      checks++;
      if (cannon_x_motion !== exp) begin
        errors++; $display("FAIL motion_alias_a tick %0d: got %h expected %h", i + 1, cannon_x_motion, exp);
      end
    end
    keycode = 8'h2C; shot_active = 1'b1; run_frame();
    checks++; if (cannon_x_motion !== 10'h000) begin errors++; $display("FAIL motion_fire_key: got %h expected 000", cannon_x_motion); end
    keycode = 8'h00; shot_active = 1'b0; run_frame();
  endtask

`ifndef AUTOFIRE_EN
  task automatic test_fire_release();
    int p0;
    int c0;
    do_reset();
    p0 = pulse_count; c0 = pulse_cycles;
    keycode = 8'h2C; run_frame();
    checks++; if (pulse_count - p0 !== 1) begin errors++; $display("FAIL fire_first: got %0d pulses expected 1", pulse_count - p0); end
    checks++; if (pulse_cycles - c0 !== 1) begin errors++; $display("FAIL fire_width: got %0d cycles expected 1", pulse_cycles - c0); end
    checks++; if (fire_state !== 2'd2) begin errors++; $display("FAIL fire_to_cooldown: got %0d expected 2", fire_state); end
    run_frames(40);
    checks++; if (pulse_count - p0 !== 1) begin errors++; $display("FAIL fire_hold_no_refire: got %0d pulses expected 1", pulse_count - p0); end
    checks++; if (fire_state !== 2'd3) begin errors++; $display("FAIL fire_wait_rel: got %0d expected 3", fire_state); end
    keycode = 8'h00; run_frame();
    checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL fire_release_idle: got %0d expected 0", fire_state); end
    keycode = 8'h2C; run_frame();
    checks++; if (pulse_count - p0 !== 2) begin errors++; $display("FAIL fire_repress: got %0d pulses expected 2", pulse_count - p0); end
    keycode = 8'h00;
  endtask
`else
  task automatic test_autofire();
    int p0;
    do_reset();
    p0 = pulse_count;
    keycode = 8'h2C; run_frame();
    checks++; if (pulse_count - p0 !== 1) begin errors++; $display("FAIL auto_first: got %0d expected 1", pulse_count - p0); end
    run_frames(3);
    checks++; if (pulse_count - p0 !== 1) begin errors++; $display("FAIL auto_gap: got %0d expected 1", pulse_count - p0); end
    run_frame();
    checks++; if (pulse_count - p0 !== 2) begin errors++; $display("FAIL auto_second: got %0d expected 2", pulse_count - p0); end
    run_frames(7);
    checks++; if (pulse_count - p0 !== 3) begin errors++; $display("FAIL auto_third: got %0d expected 3", pulse_count - p0); end
    keycode = 8'h00;
  endtask
`endif

  task automatic test_shot_active();
    int p0;
    do_reset();
    p0 = pulse_count;
    keycode = 8'h2C; shot_active = 1'b1;
    run_frames(3);
    checks++; if (pulse_count - p0 !== 0) begin errors++; $display("FAIL shot_block: got %0d pulses expected 0", pulse_count - p0); end
    checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL shot_block_state: got %0d expected 0", fire_state); end
    shot_active = 1'b0; run_frame();
    checks++; if (pulse_count - p0 !== 1) begin errors++; $display("FAIL shot_release: got %0d pulses expected 1", pulse_count - p0); end
    keycode = 8'h00;
  endtask

  task automatic test_reset_in_cooldown();
    int p0;
    do_reset();
    p0 = pulse_count;
    keycode = 8'h2C;
    run_frames(2);
    checks++; if (fire_state !== 2'd2) begin errors++; $display("FAIL rst_cd_pre_state: got %0d expected 2", fire_state); end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (fire_state !== 2'd0) begin errors++; $display("FAIL rst_cd_state: got %0d expected 0", fire_state); end
    checks++; if (cannon_x_motion !== 10'd0) begin errors++; $display("FAIL rst_cd_motion: got %h expected 000", cannon_x_motion); end
    checks++; if (fire_pulse !== 1'b0) begin errors++; $display("FAIL rst_cd_pulse: got %b expected 0", fire_pulse); end
    Reset = 1'b0;
    run_frame();
    checks++; if (pulse_count - p0 !== 2) begin errors++; $display("FAIL rst_cd_refire: got %0d pulses expected 2", pulse_count - p0); end
    keycode = 8'h00;
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_motion();
`ifndef AUTOFIRE_EN
    test_fire_release();
`else
    test_autofire();
`endif
    test_shot_active();
    test_reset_in_cooldown();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
